// File: rtl/pair_pack_ctrl.sv
// pair_pack_ctrl: collects two half-vector beats into one full vector.
// The first beat goes to the low half and the second to the high half.
// A flush emits a single pending half with its high half zero-filled.
// The controller also counts the full vectors handed downstream.
module pair_pack_ctrl #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int cnt_width     = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [element_width*(no_of_units/2)-1:0]      in_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          flush,
  output logic [2*element_width*(no_of_units/2)-1:0]    out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          out_partial,
  output logic                                          sel,
  output logic [cnt_width-1:0]                          vec_count
);

  localparam int NH = no_of_units / 2;
  localparam int HW = element_width * NH;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 partial_reg, partial_next;
  logic [cnt_width-1:0] vec_count_reg;

  logic acc, hs;
  logic load_low, load_high, clear_high;

  // A held vector can only make room for a new beat in the cycle it leaves.
  // Gating with rst_n keeps the controller from accepting beats during reset.
  assign in_ready    = rst_n & ((state_reg == ST_FULL) ? out_ready : 1'b1);
  assign out_valid   = (state_reg == ST_FULL);
  assign sel         = (state_reg == ST_HIGH);
  assign out_partial = partial_reg;
  assign vec_count   = vec_count_reg;

  assign acc = in_valid & in_ready;
  assign hs  = out_valid & out_ready;

  // State register and partial flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_LOW;
      partial_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      partial_reg <= partial_next;
    end
  end

  // Next-state and assembly-register write strobes.
  always_comb begin
    state_next   = state_reg;
    partial_next = partial_reg;
    load_low     = 1'b0;
    load_high    = 1'b0;
    clear_high   = 1'b0;
    case (state_reg)
      ST_LOW: begin
        // A flush with no pending half has nothing to emit.
        if (acc) begin
          load_low   = 1'b1;
          clear_high = 1'b1;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // A real beat takes priority over a flush in the same cycle.
        if (acc) begin
          load_high    = 1'b1;
          partial_next = 1'b0;
          state_next   = ST_FULL;
        end else if (flush) begin
          partial_next = 1'b1;
          state_next   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (hs) begin
          partial_next = 1'b0;
          if (acc) begin
            load_low   = 1'b1;
            clear_high = 1'b1;
            state_next = ST_HIGH;
          end else begin
            state_next = ST_LOW;
          end
        end
      end
      default: begin
        state_next   = ST_LOW;
        partial_next = 1'b0;
      end
    endcase
  end

  // Per-element lanes of the assembly register. The low lanes take the first
  // beat. The high lanes take the second beat, or are zeroed when a new
  // vector starts so that a later flush emits zero fill.
  genvar gi;
  generate
    for (gi = 0; gi < NH; gi++) begin : g_lane
      logic [element_width-1:0] lo_reg;
      logic [element_width-1:0] hi_reg;

      // Low-half lane capture.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo_reg <= '0;
        end else if (load_low) begin
          lo_reg <= in_data[gi*element_width +: element_width];
        end
      end

      // High-half lane capture, cleared at the start of each vector.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hi_reg <= '0;
        end else if (load_high) begin
          hi_reg <= in_data[gi*element_width +: element_width];
        end else if (clear_high) begin
          hi_reg <= '0;
        end
      end

      assign out_data[gi*element_width +: element_width]      = lo_reg;
      assign out_data[HW + gi*element_width +: element_width] = hi_reg;
    end
  endgenerate

  // Count of handed-off vectors, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count_reg <= '0;
    end else if (hs) begin
      vec_count_reg <= vec_count_reg + cnt_width'(1);
    end
  end

endmodule

// File: tb/tb_pair_pack_ctrl.sv
// tb_pair_pack_ctrl: directed checks for pair_pack_ctrl.
// The bench drives a default-size instance and a 4-bit-counter instance from
// the same stimulus. The second instance exercises counter wrap.
module tb_pair_pack_ctrl;

  localparam int HW = 128;

  logic            clk;
  logic            rst_n;
  logic [HW-1:0]   in_data;
  logic            in_valid;
  logic            flush;
  logic            out_ready;

  logic            in_ready;
  logic [2*HW-1:0] out_data;
  logic            out_valid;
  logic            out_partial;
  logic            sel;
  logic [15:0]     vec_count;

  logic            w_in_ready;
  logic [2*HW-1:0] w_out_data;
  logic            w_out_valid;
  logic            w_out_partial;
  logic            w_sel;
  logic [3:0]      w_vec_count;

  int n_checks;
  int n_pass;

  pair_pack_ctrl #(.no_of_units(8), .element_width(32), .cnt_width(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_partial(out_partial),
    .sel(sel), .vec_count(vec_count)
  );

  pair_pack_ctrl #(.no_of_units(8), .element_width(32), .cnt_width(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(w_in_ready), .flush(flush), .out_data(w_out_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_partial(w_out_partial),
    .sel(w_sel), .vec_count(w_vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and report it.
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-18s obs=%0h", tag, obs);
    end else begin
      $display("FAIL %-18s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HW-1:0] beat(input int k);
    logic [31:0] w;
    w = k;
    return {w, w, w, w};
  endfunction

  logic [HW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;
  int exp_cnt;
  int vec_seen;
  int vec_bad;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pat_a = {32{4'hA}};
    pat_b = {32{4'hB}};
    pat_c = {32{4'hC}};
    pat_d = {32{4'hD}};
    pat_e = {32{4'hE}};
    pat_f = {32{4'hF}};
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    exp_cnt = 0;

    // Reset state.
    #3;
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_sel", 256'(sel), 256'(0));
    check("rst_vec_count", 256'(vec_count), 256'(0));
    check("rst_out_data", out_data, 256'(0));
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 256'(in_ready), 256'(1));

    // Two beats form one vector; out_ready is high throughout.
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = pat_a;
    tick();
    check("a_sel_high", 256'(sel), 256'(1));
    check("a_no_valid", 256'(out_valid), 256'(0));
    in_data = pat_b;
    tick();
    in_valid = 1'b0;
    check("ab_valid", 256'(out_valid), 256'(1));
    check("ab_data", out_data, {pat_b, pat_a});
    check("ab_partial", 256'(out_partial), 256'(0));
    check("ab_sel", 256'(sel), 256'(0));
    check("ab_w_data", w_out_data, {pat_b, pat_a});
    check("ab_w_partial", 256'(w_out_partial), 256'(0));
    check("ab_w_sel", 256'(w_sel), 256'(0));
    tick();
    exp_cnt = 1;
    check("ab_count", 256'(vec_count), 256'(exp_cnt));
    check("ab_valid_drop", 256'(out_valid), 256'(0));

    // Backpressure: a held vector stays stable and blocks new beats.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = pat_c;
    tick();
    in_data = pat_d;
    tick();
    in_data = pat_e;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 256'(out_valid), 256'(1));
      check("bp_data", out_data, {pat_d, pat_c});
      check("bp_in_ready", 256'(in_ready), 256'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 256'(in_ready), 256'(1));
    tick();
    exp_cnt = 2;
    check("bp_sel_high", 256'(sel), 256'(1));
    check("bp_no_bubble", 256'(out_valid), 256'(0));
    check("bp_count", 256'(vec_count), 256'(exp_cnt));
    in_data = pat_f;
    tick();
    in_valid = 1'b0;
    check("ef_data", out_data, {pat_f, pat_e});
    tick();
    exp_cnt = 3;
    check("ef_count", 256'(vec_count), 256'(exp_cnt));

    // Flush emits the pending half with a zero high half.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 128'h1234;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 256'(out_valid), 256'(1));
    check("fl_data", out_data, {128'h0, 128'h1234});
    check("fl_partial", 256'(out_partial), 256'(1));
    out_ready = 1'b1;
    tick();
    exp_cnt = 4;
    check("fl_count", 256'(vec_count), 256'(exp_cnt));
    out_ready = 1'b0;

    // A flush in LOW has no pending half to emit.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_low_valid", 256'(out_valid), 256'(0));
    check("fl_low_sel", 256'(sel), 256'(0));

    // A flush together with the second beat gives a full vector.
    in_valid = 1'b1; in_data = beat(5);
    tick();
    in_data = beat(6); flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("fl_beat_data", out_data, {beat(6), beat(5)});
    check("fl_beat_partial", 256'(out_partial), 256'(0));
    out_ready = 1'b1;
    tick();
    exp_cnt = 5;

    // Streaming: 20 back-to-back beats give 10 vectors in order.
    vec_seen = 0; vec_bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = beat(100 + i);
      tick();
      if (out_valid) begin
        if (out_data !== {beat(100 + 2*vec_seen + 1), beat(100 + 2*vec_seen)})
          vec_bad++;
        vec_seen++;
      end
    end
    in_valid = 1'b0;
    tick();
    exp_cnt = 15;
    check("st_vectors", 256'(vec_seen), 256'(10));
    check("st_bad_data", 256'(vec_bad), 256'(0));
    check("st_count", 256'(vec_count), 256'(exp_cnt));
    check("st_w_count", 256'(w_vec_count), 256'(15));

    // Reset asserted while in HIGH.
    in_valid = 1'b1; in_data = beat(7);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rh_valid", 256'(out_valid), 256'(0));
    check("rh_sel", 256'(sel), 256'(0));
    check("rh_count", 256'(vec_count), 256'(0));
    #1 rst_n = 1'b1;
    tick();

    // Reset asserted while in FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = beat(8);
    tick();
    in_data = beat(9);
    tick();
    in_valid = 1'b0;
    check("rf_pre_valid", 256'(out_valid), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rf_valid", 256'(out_valid), 256'(0));
    check("rf_sel", 256'(sel), 256'(0));
    check("rf_count", 256'(vec_count), 256'(0));
    check("rf_data", out_data, 256'(0));
    #1 rst_n = 1'b1;
    tick();

    // A clean vector follows the reset.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = beat(11);
    tick();
    in_data = beat(12);
    tick();
    in_valid = 1'b0;
    check("rc_data", out_data, {beat(12), beat(11)});
    check("rc_partial", 256'(out_partial), 256'(0));
    tick();
    check("rc_count", 256'(vec_count), 256'(1));

    // Counter wrap: 16 more handoffs take the 4-bit counter to 17 mod 16.
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = beat(200 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("wrap_w_count", 256'(w_vec_count), 256'(1));
    check("wrap_count", 256'(vec_count), 256'(17));
    check("wrap_w_valid", 256'(w_out_valid), 256'(0));
    check("wrap_w_ready", 256'(w_in_ready), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound the run in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pair_pack_ctrl.md
Name: pair_pack_ctrl

Overview:
- Sequencing controller for the half-to-full vector demux path in the solver datapath.
- Accepts half-vectors of no_of_units/2 elements over a valid/ready stream and steers each into the low or high half of a full-width assembly register.
- Presents the assembled full vector (no_of_units elements) downstream with its own valid/ready handshake.
- Supports flushing a half-filled vector (upper half zero) and keeps a count of emitted vectors.

Parameters:
- no_of_units, 8, elements in a full vector; must be even and >= 2.
- element_width, 32, bits per element.
- cnt_width, 16, width of the emitted-vector counter.
- HW (derived, not overridable) = element_width*(no_of_units/2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  HW  half-vector beat.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts beat this cycle.
- flush  input  1  single-cycle pulse; emit a pending half vector.
- out_data  output  2*HW  assembled vector; low half = first beat, high half = second beat.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_partial  output  1  with out_valid: high half is zero-fill from a flush.
- sel  output  1  half the next accepted beat is written to (0 = low, 1 = high).
- vec_count  output  cnt_width  number of vectors handed off (out_valid & out_ready).

Behaviour:
- Reset (async, rst_n=0):
  - state=LOW, out_data=0, out_valid=0, out_partial=0, sel=0, vec_count=0.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
- Accept event: acc = in_valid & in_ready.
- Handoff event: hs = out_valid & out_ready.
- State LOW (sel=0, out_valid=0):
  - in_ready=1.
  - acc: out_data[HW-1:0]<=in_data, out_data[2HW-1:HW]<=0, next state HIGH.
  - flush ignored.
- State HIGH (sel=1, out_valid=0):
  - in_ready=1.
  - acc: out_data[2HW-1:HW]<=in_data, out_partial<=0, next state FULL.
  - flush without acc: out_partial<=1, next state FULL (high half stays 0).
  - flush with acc in the same cycle: the beat wins; full vector is formed, out_partial=0, flush dropped.
- State FULL (out_valid=1, sel=0):
  - in_ready = out_ready. A beat is taken only in the same cycle the held vector leaves.
  - out_data and out_partial are held stable while out_valid & !out_ready.
  - hs & !acc: out_valid<=0, next state LOW.
  - hs & acc: low half <= in_data, high half <= 0, out_partial<=0, next state HIGH. No bubble.
  - flush ignored.
- Latency: out_valid rises the cycle after the second beat (or flush) is registered. Throughput is one full vector per 2 cycles with out_ready held high.
- vec_count increments by 1 on each hs and wraps from 2^cnt_width-1 to 0.
- Reset mid-operation discards any partial or held vector; no output beat is produced for it.
- The out_data and sel mapping is fixed: sel=0 writes the low half, sel=1 writes the high half, matching the demux select polarity.
- Illegal state encodings recover to LOW on the next clock.

Test Plan:
- Reset then two beats (no_of_units=8, element_width=32), out_ready=1: in_data=128'hA…A then 128'hB…B -> out_valid one cycle after second accept, out_data={B…B,A…A}, out_partial=0, vec_count=1.
- Backpressure: out_ready=0 for 5 cycles with a full vector held -> out_data and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> handoff and low-half capture in the same cycle, state HIGH, vec_count increments.
- Flush: one beat 128'h1234 then flush pulse -> out_data={128'h0,128'h1234}, out_partial=1. Flush in LOW, or with a beat in HIGH, produces no partial vector.
- Streaming: 20 beats back-to-back, out_ready=1 -> 10 vectors in order, no dropped or duplicated beat, vec_count=10.
- Async reset asserted while in HIGH and while in FULL -> immediate out_valid=0, sel=0, vec_count=0. After release, the next two beats form a clean vector.
- Counter wrap: cnt_width=4, 17 handoffs -> vec_count reads 1.
